mult_sched: RTL and testbench

MULT_SCHED -- requirements
Module: mult_sched

---
 rtl/mult_sched.sv | 137 +++++++++++++
 tb/tb_mult_sched.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sched.sv
`timescale 1ns/1ps
// Two requesters share one fractional multiplier through a three-stage pipeline
// (operand, product, accumulate) that updates per-requester 56-bit accumulators.
module mult_sched #(
  parameter int DATA_W = 24,
  parameter int COEF_W = 24,
  parameter int ACC_W  = 56
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req0,
  input  logic                     req1,
  input  logic [1:0]               op0,
  input  logic [1:0]               op1,
  input  logic [DATA_W-1:0]        x0,
  input  logic [COEF_W-1:0]        y0,
  input  logic [DATA_W-1:0]        x1,
  input  logic [COEF_W-1:0]        y1,
  input  logic                     hold,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic [DATA_W-1:0]        mx,
  output logic [COEF_W-1:0]        my,
  input  logic [DATA_W+COEF_W-1:0] mprod,
  output logic                     rvalid,
  output logic                     rid,
  output logic [ACC_W-1:0]         racc,
  output logic                     busy
);

  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic [1:0] OP_MPY  = 2'b00;
  localparam logic [1:0] OP_MAC  = 2'b01;
  localparam logic [1:0] OP_MACN = 2'b10;

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  // Plain two's-complement wrap; no saturation anywhere in the accumulator path.
  function automatic logic signed [ACC_W-1:0] acc_update(
    input logic [1:0]              op,
    input logic signed [ACC_W-1:0] acc,
    input logic signed [ACC_W-1:0] p
  );
    case (op)
      OP_MPY:  return p;
      OP_MAC:  return acc + p;
      OP_MACN: return acc - p;
      default: return '0;
    endcase
  endfunction

  logic                    last_gnt;
  logic                    pick1;
  logic                    accept;
  logic                    vld_p0, vld_p1, vld_p2, rvalid_q;
  logic                    id_p0, id_p1, id_p2;
  logic [1:0]              op_p0, op_p1, op_p2;
  logic signed [ACC_W-1:0] prod_p1, prod_p2;
  logic signed [ACC_W-1:0] acc0, acc1, acc_cur, acc_nxt;

  // last_gnt=1 means requester 1 won most recently, so requester 0 wins the next tie.
  always_comb begin
    pick1  = req1 & (~req0 | ~last_gnt);
    gnt0   = reset_n & ~hold & req0 & ~pick1;
    gnt1   = reset_n & ~hold & pick1;
    accept = gnt0 | gnt1;
  end

  always_comb begin
    acc_cur = id_p2 ? acc1 : acc0;
    acc_nxt = acc_update(op_p2, acc_cur, prod_p2);
    rvalid  = rvalid_q & ~hold;
    busy    = vld_p0 | vld_p1 | vld_p2 | rvalid_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt <= 1'b1;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      rvalid_q <= 1'b0;
    end else if (!hold) begin
      if (accept) last_gnt <= gnt1;
      vld_p0   <= accept;
      vld_p1   <= vld_p0;
      vld_p2   <= vld_p1;
      rvalid_q <= vld_p2;
    end
  end

  // S1: operand register; mx/my keep their last values when nothing is granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mx <= '0;
      my <= '0;
    end else if (!hold && accept) begin
      mx <= gnt1 ? x1 : x0;
      my <= gnt1 ? y1 : y0;
    end
  end

  // S1 tags, S2 product capture, S3 product/tag register.
  always_ff @(posedge clk) begin
    if (!hold) begin
      if (accept) begin
        id_p0 <= gnt1;
        op_p0 <= gnt1 ? op1 : op0;
      end
      prod_p1 <= sext_prod(mprod);
      id_p1   <= id_p0;
      op_p1   <= op_p0;
      prod_p2 <= prod_p1;
      id_p2   <= id_p1;
      op_p2   <= op_p1;
    end
  end

  // Accumulator write and result register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc0 <= '0;
      acc1 <= '0;
      rid  <= 1'b0;
      racc <= '0;
    end else if (!hold && vld_p2) begin
      if (id_p2) acc1 <= acc_nxt;
      else       acc0 <= acc_nxt;
      rid  <= id_p2;
      racc <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
`timescale 1ns/1ps
// Bench for mult_sched: fractional multiplier model, arbitration/accumulator
// scoreboard, a table of single operations and hand-written corner sequences.
module tb_mult_sched;

  logic        clk = 1'b0;
  logic        reset_n, req0, req1, hold;
  logic [1:0]  op0, op1;
  logic [23:0] x0, y0, x1, y1, mx, my;
  logic        gnt0, gnt1, rvalid, rid, busy;
  logic [47:0] mprod;
  logic [55:0] racc;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        id;
    logic [55:0] racc;
    int          due;
  } exp_t;

  typedef struct {
    logic        rq;
    logic [1:0]  op;
    logic [23:0] x;
    logic [23:0] y;
    logic [55:0] exp;
  } vec_t;

  exp_t        scb[$];
  logic [55:0] m_acc0 = '0;
  logic [55:0] m_acc1 = '0;
  logic        m_last = 1'b1;
  int          eff    = 0;

  always #5 clk = ~clk;

  mult_sched dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .hold(hold), .gnt0(gnt0), .gnt1(gnt1),
    .mx(mx), .my(my), .mprod(mprod),
    .rvalid(rvalid), .rid(rid), .racc(racc), .busy(busy)
  );

  // Q23 x Q23 fractional multiplier: signed product shifted left by one.
  function automatic logic [47:0] frac_mul(input logic [23:0] a, input logic [23:0] b);
    logic signed [47:0] sa, sb, t;
    sa = {{24{a[23]}}, a};
    sb = {{24{b[23]}}, b};
    t  = sa * sb;
    return {t[46:0], 1'b0};
  endfunction

  function automatic logic [55:0] model_acc(input logic [1:0] op, input logic [55:0] a,
                                            input logic [47:0] p);
    logic [55:0] pe;
    pe = {{8{p[47]}}, p};
    case (op)
      2'b00:   return pe;
      2'b01:   return a + pe;
      2'b10:   return a - pe;
      default: return 56'd0;
    endcase
  endfunction

  always_comb mprod = frac_mul(mx, my);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input string nm, input logic which);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      got = which ? gnt1 : gnt0;
    end
    chk(nm, 64'(got), 64'd1);
  endtask

  task automatic wait_rvalid(input string nm);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      got = rvalid;
    end
    chk(nm, 64'(got), 64'd1);
  endtask

  // Scoreboard: arbitration model, accumulator model and result timing.
  always @(negedge clk) begin : mon
    logic        eg0, eg1, gid;
    logic [1:0]  gop;
    logic [23:0] gx, gy;
    logic [55:0] nacc;
    if (!reset_n) begin
      scb.delete();
      m_acc0 = '0;
      m_acc1 = '0;
      m_last = 1'b1;
      chk("rst_gnt", 64'({gnt1, gnt0}), 64'd0);
      chk("rst_rvalid", 64'(rvalid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_racc", 64'(racc), 64'd0);
      chk("rst_mxmy", 64'({mx, my}), 64'd0);
    end else begin
      eg0 = ~hold & req0 & (~req1 | m_last);
      eg1 = ~hold & req1 & (~req0 | ~m_last);
      if (!hold && scb.size() > 0 && scb[0].due == eff) begin
        chk("res_rvalid", 64'(rvalid), 64'd1);
        chk("res_rid", 64'(rid), 64'(scb[0].id));
        chk("res_racc", 64'(racc), 64'(scb[0].racc));
        void'(scb.pop_front());
      end else begin
        chk("idle_rvalid", 64'(rvalid), 64'd0);
      end
      chk("gnt", 64'({gnt1, gnt0}), 64'({eg1, eg0}));
      if (eg0 | eg1) begin
        gid  = eg1;
        gop  = eg1 ? op1 : op0;
        gx   = eg1 ? x1 : x0;
        gy   = eg1 ? y1 : y0;
        nacc = model_acc(gop, gid ? m_acc1 : m_acc0, frac_mul(gx, gy));
        if (gid) m_acc1 = nacc;
        else     m_acc0 = nacc;
        m_last = gid;
        scb.push_back('{id: gid, racc: nacc, due: eff + 4});
      end
      if (!hold) eff++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[9];
    logic [55:0] hold_exp[3];

    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; hold = 1'b0;
    op0 = 2'b00; op1 = 2'b00;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;

    tbl[0] = '{1'b0, 2'b00, 24'h400000, 24'h400000, 56'h00_2000_0000_0000};
    tbl[1] = '{1'b1, 2'b00, 24'h400000, 24'hC00000, 56'hFF_E000_0000_0000};
    tbl[2] = '{1'b0, 2'b01, 24'h400000, 24'h400000, 56'h00_4000_0000_0000};
    tbl[3] = '{1'b0, 2'b10, 24'h400000, 24'hC00000, 56'h00_6000_0000_0000};
    tbl[4] = '{1'b1, 2'b01, 24'h7FFFFF, 24'h7FFFFF, 56'h00_5FFF_FE00_0002};
    tbl[5] = '{1'b1, 2'b00, 24'h800000, 24'h800000, 56'hFF_8000_0000_0000};
    tbl[6] = '{1'b0, 2'b10, 24'h800000, 24'h7FFFFF, 56'h00_DFFF_FF00_0000};
    tbl[7] = '{1'b1, 2'b11, 24'h123456, 24'h654321, 56'h00_0000_0000_0000};
    tbl[8] = '{1'b0, 2'b00, 24'h000001, 24'h000001, 56'h00_0000_0000_0002};
    hold_exp = '{56'h00_4000_0000_0000, 56'h00_6000_0000_0000, 56'h00_8000_0000_0000};

    tick();
    tick();
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rq) begin
        req1 = 1'b1; op1 = tbl[i].op; x1 = tbl[i].x; y1 = tbl[i].y;
      end else begin
        req0 = 1'b1; op0 = tbl[i].op; x0 = tbl[i].x; y0 = tbl[i].y;
      end
      wait_gnt("tbl_gnt", tbl[i].rq);
      tick();
      req0 = 1'b0;
      req1 = 1'b0;
      wait_rvalid("tbl_rvalid");
      chk("tbl_rid", 64'(rid), 64'(tbl[i].rq));
      chk("tbl_racc", 64'(racc), 64'(tbl[i].exp));
      tick();
    end

    // Back-to-back MPY then MAC from requester 0.
    req0 = 1'b1; op0 = 2'b00; x0 = 24'h400000; y0 = 24'h400000;
    tick();
    op0 = 2'b01;
    tick();
    req0 = 1'b0;
    wait_rvalid("b2b_first");
    chk("b2b_racc0", 64'(racc), 64'(56'h00_2000_0000_0000));
    @(negedge clk);
    chk("b2b_rvalid1", 64'(rvalid), 64'd1);
    chk("b2b_racc1", 64'(racc), 64'(56'h00_4000_0000_0000));
    tick();

    // Contention directly after reset: alternating grants starting with 0.
    reset_n = 1'b0;
    tick();
    tick();
    req0 = 1'b1; req1 = 1'b1; op0 = 2'b00; op1 = 2'b00;
    x0 = 24'h400000; y0 = 24'h400000; x1 = 24'h400000; y1 = 24'hC00000;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arb_gnt0", 64'(gnt0), (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("arb_gnt1", 64'(gnt1), (i % 2 == 0) ? 64'd0 : 64'd1);
      tick();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    wait_rvalid("arb_first");
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("arb_rvalid", 64'(rvalid), 64'd1);
      chk("arb_rid", 64'(rid), (i % 2 == 0) ? 64'd0 : 64'd1);
    end
    tick();

    // Hold for two cycles with S1..S3 full.
    req0 = 1'b1; op0 = 2'b01; x0 = 24'h400000; y0 = 24'h400000;
    tick();
    tick();
    tick();
    req0 = 1'b0; hold = 1'b1; req1 = 1'b1; op1 = 2'b11;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hold_busy", 64'(busy), 64'd1);
      chk("hold_gnt1", 64'(gnt1), 64'd0);
      chk("hold_rvalid", 64'(rvalid), 64'd0);
      tick();
    end
    hold = 1'b0;
    @(negedge clk);
    chk("hold_gap", 64'(rvalid), 64'd0);
    tick();
    req1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_resume_v", 64'(rvalid), 64'd1);
      chk("hold_resume_racc", 64'(racc), 64'(hold_exp[i]));
    end
    repeat (6) tick();

    // Reset with three operations in flight.
    req0 = 1'b1; op0 = 2'b01; x0 = 24'h400000; y0 = 24'h400000;
    tick();
    tick();
    tick();
    req0 = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_rvalid", 64'(rvalid), 64'd0);
    end
    tick();
    req0 = 1'b1;
    wait_gnt("rst_mac_gnt", 1'b0);
    tick();
    req0 = 1'b0;
    wait_rvalid("rst_mac_rvalid");
    chk("rst_mac_rid", 64'(rid), 64'd0);
    chk("rst_mac_racc", 64'(racc), 64'(56'h00_2000_0000_0000));

    repeat (6) tick();
    chk("scb_empty", 64'(scb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
